// File: rtl/lcd_pkg.sv
// Purpose: shared constants for the LCD command arbiter. These are the instruction
//          codes, the default reservation lengths and the arbiter state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package lcd_pkg;

  localparam int TIMER_W = 17;

  localparam int unsigned CMD_CYCLES_DEF   = 2081;
  localparam int unsigned CLEAR_CYCLES_DEF = 82001;
  localparam int unsigned START_PULSE_DEF  = 2;

  localparam logic [3:0] INSTR_NOP        = 4'b0000;
  localparam logic [3:0] INSTR_CLEAR      = 4'b0001;
  localparam logic [3:0] INSTR_ENTRY_MODE = 4'b0011;
  localparam logic [3:0] INSTR_DISPLAY_ON = 4'b0100;
  localparam logic [3:0] INSTR_FUNC_SET   = 4'b0110;
  localparam logic [3:0] INSTR_SET_DDRAM  = 4'b1000;
  localparam logic [3:0] INSTR_WRITE_DATA = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lcd_wait_timer.sv
// Purpose: loadable 17-bit down counter that marks the last cycle of a reservation.
// Latency: expire is high in cycle len-1 when counted from the load-completion cycle (cycle 0).
// Backpressure: none. The counter saturates at zero and never wraps.
// Ports: clk, sync_reset (async, active-high), load/len (start a reservation),
//        expire (one-cycle pulse).
module lcd_wait_timer
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               sync_reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] len,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt;

  // After a load, cnt equals len - k in cycle k, so cnt == 1 marks cycle len-1.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == TIMER_W'(1));

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Purpose: round-robin share of the single LCD command_fsm between two requesters.
//          Each grant reserves the LCD for a fixed number of cycles.
// Latency: gnt arrives 1 cycle after req is seen in IDLE. done arrives L cycles after gnt.
// Backpressure: req is held until gnt. Any request raised while busy waits for IDLE.
// Ports: clk, sync_reset (async, active-high); req[1:0] with req_instr_*/req_db_*;
//        gnt/done one-hot pulses; busy; ready/DB/instruction go to command_fsm.
module lcd_cmd_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_CYCLES   = CMD_CYCLES_DEF,
  parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int unsigned START_PULSE  = START_PULSE_DEF
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [1:0] req,
  input  logic [3:0] req_instr_0,
  input  logic [3:0] req_instr_1,
  input  logic [7:0] req_db_0,
  input  logic [7:0] req_db_1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       ready,
  output logic [7:0] DB,
  output logic [3:0] instruction
);

  localparam int PW = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;

  state_t             state, state_nxt;
  logic               owner;
  logic               last;
  logic               win;
  logic [3:0]         win_instr;
  logic [7:0]         win_db;
  logic [TIMER_W-1:0] win_len;
  logic               capture;
  logic               expire;
  logic [PW-1:0]      pulse_cnt;
  logic [1:0]         gnt_nxt;
  logic [1:0]         done_nxt;
  logic               ready_nxt;

  // On a tie, the requester that was not served last wins. A lone requester always wins.
  always_comb begin
    win       = (req == 2'b11) ? ~last : req[1];
    win_instr = win ? req_instr_1 : req_instr_0;
    win_db    = win ? req_db_1    : req_db_0;
    if (win_instr == INSTR_CLEAR) begin
      win_len = TIMER_W'(CLEAR_CYCLES);
    end else if (win_instr == INSTR_NOP) begin
      win_len = TIMER_W'(1);
    end else begin
      win_len = TIMER_W'(CMD_CYCLES);
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    gnt_nxt   = 2'b00;
    done_nxt  = 2'b00;
    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          capture      = 1'b1;
          gnt_nxt[win] = 1'b1;
          state_nxt    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A no-op expires during its first cycle, so expire takes priority.
        if (expire) begin
          done_nxt[owner] = 1'b1;
          state_nxt       = ST_DONE;
        end else if (pulse_cnt == PW'(START_PULSE - 1)) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (expire) begin
          done_nxt[owner] = 1'b1;
          state_nxt       = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // ready follows ISSUE, except that a no-op never strobes command_fsm.
    ready_nxt = (state_nxt == ST_ISSUE) &&
                ((capture ? win_instr : instruction) != INSTR_NOP);
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state       <= ST_IDLE;
      gnt         <= 2'b00;
      done        <= 2'b00;
      ready       <= 1'b0;
      DB          <= 8'h00;
      instruction <= 4'h0;
      owner       <= 1'b0;
      last        <= 1'b1;
      pulse_cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      ready <= ready_nxt;
      if (capture) begin
        owner       <= win;
        DB          <= win_db;
        instruction <= win_instr;
        pulse_cnt   <= '0;
      end else if (state == ST_ISSUE) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end
      if (state == ST_DONE) begin
        last <= owner;
      end
    end
  end

  assign busy = (state != ST_IDLE);

  lcd_wait_timer u_timer (
    .clk        (clk),
    .sync_reset (sync_reset),
    .load       (capture),
    .len        (win_len),
    .expire     (expire)
  );

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
module tb_lcd_cmd_arbiter;

  localparam int CMD = 2081;
  localparam int CLR = 9001;
  localparam int GAP = CMD + 2;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [1:0] req;
  logic [3:0] req_instr_0, req_instr_1;
  logic [7:0] req_db_0, req_db_1;
  logic [1:0] gnt, done;
  logic       busy, ready;
  logic [7:0] DB;
  logic [3:0] instruction;

  lcd_cmd_arbiter #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR), .START_PULSE(2)) dut (
    .clk(clk), .sync_reset(sync_reset), .req(req),
    .req_instr_0(req_instr_0), .req_instr_1(req_instr_1),
    .req_db_0(req_db_0), .req_db_1(req_db_1),
    .gnt(gnt), .done(done), .busy(busy), .ready(ready),
    .DB(DB), .instruction(instruction)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    int         idx;
    int         at;
    logic [7:0] db;
    logic [3:0] ins;
    int         rdy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit d, input int i, input int at,
                      input logic [7:0] db, input logic [3:0] ins, input int rdy);
    exp_t e;
    e.is_done = d; e.idx = i; e.at = at; e.db = db; e.ins = ins; e.rdy = rdy;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever a gnt or done pulse appears.
  initial begin : monitor
    bit in_cmd;
    bit busy_ok;
    int rdy_cnt;
    exp_t e;
    in_cmd = 0; busy_ok = 1; rdy_cnt = 0;
    forever begin
      @(negedge clk);
      if (sync_reset) begin
        in_cmd = 0;
      end else begin
        if (in_cmd) begin
          if (ready) rdy_cnt++;
          if (!busy) busy_ok = 0;
        end
        if (gnt != 2'b00 || done != 2'b00) begin
          chk((gnt == 2'b00 || done == 2'b00) && $onehot(gnt | done), "onehot",
              int'({gnt, done}), 0);
          if (sb.size() == 0) begin
            chk(0, "unexpected_event", int'({gnt, done}), 0);
          end else begin
            e = sb.pop_front();
            chk(cyc == e.at, e.is_done ? "done_cycle" : "gnt_cycle", cyc, e.at);
            if (e.is_done) begin
              chk(done[e.idx] === 1'b1, "done_idx", int'(done), 1 << e.idx);
              chk(busy_ok, "busy_throughout", int'(busy_ok), 1);
              chk(rdy_cnt == e.rdy, "ready_cycles", rdy_cnt, e.rdy);
              in_cmd = 0;
            end else begin
              chk(gnt[e.idx] === 1'b1, "gnt_idx", int'(gnt), 1 << e.idx);
              chk(DB == e.db, "DB", int'(DB), int'(e.db));
              chk(instruction == e.ins, "instruction", int'(instruction), int'(e.ins));
              chk(ready == (e.ins != 4'b0000), "ready_at_gnt", int'(ready),
                  int'(e.ins != 4'b0000));
              chk(busy, "busy_at_gnt", int'(busy), 1);
              in_cmd = 1; busy_ok = 1; rdy_cnt = ready ? 1 : 0;
            end
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk(gnt == 2'b00, {tag, "_gnt"}, int'(gnt), 0);
    chk(done == 2'b00, {tag, "_done"}, int'(done), 0);
    chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
    chk(ready == 1'b0, {tag, "_ready"}, int'(ready), 0);
    chk(DB == 8'h00, {tag, "_DB"}, int'(DB), 0);
    chk(instruction == 4'h0, {tag, "_instr"}, int'(instruction), 0);
  endtask

  task automatic wait_gnt(input int i, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[i] !== 1'b1 && n < max);
    if (gnt[i] !== 1'b1) chk(0, "gnt_timeout", i, max);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy) && n < max);
    if (sb.size() != 0 || busy) chk(0, "idle_timeout", sb.size(), 0);
  endtask

  initial begin : stim
    int t;
    sync_reset = 1'b1;
    req = 2'b00;
    req_instr_0 = 4'h0; req_instr_1 = 4'h0;
    req_db_0 = 8'h00;   req_db_1 = 8'h00;
    #1;
    chk_reset_outputs("por");

    // Contention: both requesters high from reset, grants alternate 0,1,0,1.
    req_instr_0 = 4'b1010; req_db_0 = 8'h30;
    req_instr_1 = 4'b1010; req_db_1 = 8'h31;
    req = 2'b11;
    @(negedge clk); @(negedge clk);
    sync_reset = 1'b0;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      push(0, k % 2, t + 1 + k * GAP, (k % 2) ? 8'h31 : 8'h30, 4'b1010, 2);
      push(1, k % 2, t + 1 + k * GAP + CMD, 8'h00, 4'h0, 2);
    end
    while (cyc < t + 1 + 3 * GAP) @(negedge clk);
    req = 2'b00;
    wait_idle(GAP + 10);

    // Single write from requester 0.
    t = cyc;
    req_instr_0 = 4'b1010; req_db_0 = 8'h41; req = 2'b01;
    push(0, 0, t + 1, 8'h41, 4'b1010, 2);
    push(1, 0, t + 1 + CMD, 8'h00, 4'h0, 2);
    wait_gnt(0, 5);
    req = 2'b00;
    wait_idle(GAP + 10);

    // Reset mid-WAIT. Requester 0 was served last, so a tie after reset shows last=1.
    t = cyc;
    req_instr_1 = 4'b0110; req_db_1 = 8'h38; req = 2'b10;
    push(0, 1, t + 1, 8'h38, 4'b0110, 0);
    wait_gnt(1, 5);
    req = 2'b00;
    repeat (100) @(negedge clk);
    #1 sync_reset = 1'b1;
    #1;
    chk_reset_outputs("midwait");
    chk(sb.size() == 0, "gnt_before_reset_seen", sb.size(), 0);
    req_instr_0 = 4'b0000; req_db_0 = 8'h5A;
    req_instr_1 = 4'b0001; req_db_1 = 8'h01;
    req = 2'b11;
    @(negedge clk); @(negedge clk);
    sync_reset = 1'b0;
    t = cyc;
    // A no-op from requester 0 wins the tie, and then the clear from requester 1 follows.
    push(0, 0, t + 1, 8'h5A, 4'b0000, 0);
    push(1, 0, t + 2, 8'h00, 4'h0, 0);
    push(0, 1, t + 4, 8'h01, 4'b0001, 2);
    push(1, 1, t + 4 + CLR, 8'h00, 4'h0, 2);
    wait_gnt(0, 5);
    req[0] = 1'b0;
    wait_gnt(1, 10);
    req[1] = 1'b0;
    wait_idle(CLR + 20);

    // Dropped request: a one-cycle req[1] pulse while busy must never be granted.
    t = cyc;
    req_instr_0 = 4'b0011; req_db_0 = 8'h06; req = 2'b01;
    push(0, 0, t + 1, 8'h06, 4'b0011, 2);
    push(1, 0, t + 1 + CMD, 8'h00, 4'h0, 2);
    wait_gnt(0, 5);
    req = 2'b00;
    repeat (10) @(negedge clk);
    req_instr_1 = 4'b1000; req_db_1 = 8'h80; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    wait_idle(GAP + 10);
    t = cyc;
    req_instr_0 = 4'b0100; req_db_0 = 8'h0C; req = 2'b01;
    push(0, 0, t + 1, 8'h0C, 4'b0100, 2);
    push(1, 0, t + 1 + CMD, 8'h00, 4'h0, 2);
    wait_gnt(0, 5);
    req = 2'b00;
    wait_idle(GAP + 10);

    repeat (20) @(negedge clk);
    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    chk(busy == 1'b0, "final_idle", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "watchdog");
  end

endmodule
